branch_resolve: RTL and testbench
=================================

Name: branch_resolve

Overview:
- EX-stage branch resolution unit for conditional branches.
- Carries IF-stage prediction metadata (predict_taken, predict_target_pc) with the instruction through DEC to EX.
- In EX: evaluates the branch condition, computes the real target and detects mispredictions.
- Drives the predictor update signals (branch_ex, branch_taken_ex, branch_pc_ex, branch_target_pc) and the front-end redirect/flush. Keeps branch and mispredict performance counters.

Parameters:
ADDR_WIDTH, 32, pc/target width
DATA_WIDTH, 32, operand width
CNT_WIDTH, 32, performance counter width

Ports:
cpu_clk  input  1  core clock
cpu_rstn  input  1  asynchronous active-low reset
if_valid  input  1  fetch at pc is valid this cycle (same cycle predict_taken is valid)
predict_taken  input  1  prediction for instruction at pc
predict_target_pc  input  ADDR_WIDTH  predicted target for instruction at pc
dec_ready  input  1  IF->DEC advance this cycle
ex_ready  input  1  DEC->EX advance; EX instruction completes this cycle
branch_dec  input  1  DEC instruction is a conditional branch
funct3_dec  input  3  branch funct3 of DEC instruction
pc_dec  input  ADDR_WIDTH  pc of DEC instruction
imm_dec  input  ADDR_WIDTH  sign-extended B-type offset
src_data1_ex  input  DATA_WIDTH  rs1 operand (forwarded) in EX
src_data2_ex  input  DATA_WIDTH  rs2 operand (forwarded) in EX
flush_ext  input  1  trap/exception flush of IF and DEC
cnt_clr  input  1  synchronous clear of both counters
branch_ex  output  1  one-cycle predictor update strobe
branch_taken_ex  output  1  resolved direction
branch_pc_ex  output  ADDR_WIDTH  pc of resolved branch
branch_target_pc  output  ADDR_WIDTH  pc_ex + imm_ex
mispredict_flush  output  1  kill IF/DEC, redirect fetch
redirect_pc  output  ADDR_WIDTH  correct next pc
branch_cnt  output  CNT_WIDTH  resolved branches
mispredict_cnt  output  CNT_WIDTH  mispredictions

Behaviour:
- Reset: all stage valids 0, all metadata and counters 0; every output 0.
- flush = mispredict_flush | flush_ext.
- DEC register: on dec_ready, load {if_valid & ~flush, predict_taken, predict_target_pc}. Otherwise hold. If flush, dec_valid <= 0 regardless of dec_ready.
- EX register: on ex_ready, load {dec_valid & branch_dec & ~flush, pred bits, pc_dec, imm_dec, funct3_dec}. Otherwise hold. If flush, the incoming EX entry is invalid.
- Compare: funct3 000 BEQ, 001 BNE, 100 BLT (signed), 101 BGE (signed), 110 BLTU, 111 BGEU. Funct3 010/011 are illegal: branch_ex=0, no flush, counters unchanged.
- Resolve is combinational, only in a cycle with ex_valid & ex_ready & legal funct3; branch_ex=1 for exactly that cycle. A stalled EX (ex_ready=0) produces no outputs.
- branch_target_pc = pc_ex + imm_ex, modulo 2^ADDR_WIDTH (wraps).
- mispredict_flush = branch_ex & ((taken != pred_taken) | (taken & pred_taken & pred_target != branch_target_pc)).
- redirect_pc = taken ? branch_target_pc : pc_ex + 4. It is 0 when mispredict_flush=0.
- Counters: branch_cnt += branch_ex; mispredict_cnt += mispredict_flush. Both wrap at 2^CNT_WIDTH. cnt_clr wins over a same-cycle increment (result 0).
- Simultaneous flush_ext and mispredict: flush_ext has no effect on the EX branch itself. The mispredict and redirect still issue; the external agent arbitrates which redirect the front end takes.
- Reset mid-stall: everything returns to reset values immediately (asynchronous); no pending outputs survive.

Decomposition:
- core_defines.vh: branch funct3 encodings (BEQ..BGEU) and the ADDR_WIDTH/DATA_WIDTH defaults.
- Sub-module branch_cmp: combinational funct3/operand compare, outputs taken and legal.
- All pipeline registers, mispredict logic and counters live in branch_resolve.

Test Plan:
- BEQ, pc_dec=0x100, imm=0x20, src1=src2=5, predicted not-taken, ex_ready=1 -> branch_ex=1, taken=1, target=0x120, mispredict_flush=1, redirect_pc=0x120, mispredict_cnt=1.
- BLT src1=0xFFFFFFFF, src2=1 -> taken. BLTU with the same operands -> not taken. If BLTU was predicted taken -> redirect_pc=pc_ex+4.
- Predicted taken to 0x200, actual taken to 0x120 -> mispredict_flush=1 (target mismatch). Predicted 0x120 -> no flush, branch_cnt increments only.
- ex_ready held 0 for 3 cycles with a valid branch in EX -> branch_ex stays 0. On release, exactly one branch_ex pulse with correct resolution.
- flush_ext while a branch is in DEC -> that branch never produces branch_ex. funct3=010 in EX -> no strobe, no counter change.
- cnt_clr concurrent with a mispredict -> both counters read 0 next cycle. Counter at all-ones + branch -> wraps to 0. cpu_rstn low during a stall -> all outputs 0 immediately.

Source files
------------

// File: rtl/branch_resolve_pkg.sv
// Shared definitions for the EX-stage branch resolution slice:
// default widths and the conditional-branch funct3 encodings.
package branch_resolve_pkg;

  localparam int ADDR_WIDTH_DEF = 32;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int CNT_WIDTH_DEF  = 32;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } branch_f3_e;

endpackage

// File: rtl/branch_cmp.sv
// Combinational branch condition evaluation: decodes funct3 and compares
// the two EX operands; 010/011 are reported as illegal.
module branch_cmp
  import branch_resolve_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] src_a,
  input  logic [DATA_WIDTH-1:0] src_b,
  output logic                  taken,
  output logic                  legal
);

  logic is_eq;
  logic is_lt_s;
  logic is_lt_u;

  always_comb begin
    is_eq   = (src_a == src_b);
    is_lt_s = ($signed(src_a) < $signed(src_b));
    is_lt_u = (src_a < src_b);
    taken   = 1'b0;
    legal   = 1'b1;
    case (funct3)
      F3_BEQ:  taken = is_eq;
      F3_BNE:  taken = ~is_eq;
      F3_BLT:  taken = is_lt_s;
      F3_BGE:  taken = ~is_lt_s;
      F3_BLTU: taken = is_lt_u;
      F3_BGEU: taken = ~is_lt_u;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// EX-stage branch resolution: carries IF prediction metadata through DEC/EX,
// resolves the branch, drives predictor update, redirect and perf counters.
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                  cpu_clk,
  input  logic                  cpu_rstn,
  input  logic                  if_valid,
  input  logic                  predict_taken,
  input  logic [ADDR_WIDTH-1:0] predict_target_pc,
  input  logic                  dec_ready,
  input  logic                  ex_ready,
  input  logic                  branch_dec,
  input  logic [2:0]            funct3_dec,
  input  logic [ADDR_WIDTH-1:0] pc_dec,
  input  logic [ADDR_WIDTH-1:0] imm_dec,
  input  logic [DATA_WIDTH-1:0] src_data1_ex,
  input  logic [DATA_WIDTH-1:0] src_data2_ex,
  input  logic                  flush_ext,
  input  logic                  cnt_clr,
  output logic                  branch_ex,
  output logic                  branch_taken_ex,
  output logic [ADDR_WIDTH-1:0] branch_pc_ex,
  output logic [ADDR_WIDTH-1:0] branch_target_pc,
  output logic                  mispredict_flush,
  output logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [CNT_WIDTH-1:0]  branch_cnt,
  output logic [CNT_WIDTH-1:0]  mispredict_cnt
);

  logic                  flush;
  logic                  dec_valid;
  logic                  dec_pred_taken;
  logic [ADDR_WIDTH-1:0] dec_pred_target;
  logic                  ex_valid;
  logic                  ex_pred_taken;
  logic [ADDR_WIDTH-1:0] ex_pred_target;
  logic [ADDR_WIDTH-1:0] ex_pc;
  logic [ADDR_WIDTH-1:0] ex_imm;
  logic [2:0]            ex_funct3;
  logic                  cmp_taken;
  logic                  cmp_legal;
  logic [ADDR_WIDTH-1:0] target_sum;
  logic [ADDR_WIDTH-1:0] fallthrough_pc;

  assign flush = mispredict_flush | flush_ext;

  // A flush kills the DEC slot even when the stage is not advancing.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      dec_valid       <= 1'b0;
      dec_pred_taken  <= 1'b0;
      dec_pred_target <= '0;
    end else begin
      if (dec_ready) begin
        dec_valid       <= if_valid & ~flush;
        dec_pred_taken  <= predict_taken;
        dec_pred_target <= predict_target_pc;
      end
      if (flush) begin
        dec_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      ex_valid       <= 1'b0;
      ex_pred_taken  <= 1'b0;
      ex_pred_target <= '0;
      ex_pc          <= '0;
      ex_imm         <= '0;
      ex_funct3      <= '0;
    end else if (ex_ready) begin
      ex_valid       <= dec_valid & branch_dec & ~flush;
      ex_pred_taken  <= dec_pred_taken;
      ex_pred_target <= dec_pred_target;
      ex_pc          <= pc_dec;
      ex_imm         <= imm_dec;
      ex_funct3      <= funct3_dec;
    end
  end

  branch_cmp #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_cmp (
    .funct3(ex_funct3),
    .src_a (src_data1_ex),
    .src_b (src_data2_ex),
    .taken (cmp_taken),
    .legal (cmp_legal)
  );

  // All resolution outputs read zero unless a legal branch completes this cycle.
  always_comb begin
    target_sum       = ex_pc + ex_imm;
    fallthrough_pc   = ex_pc + ADDR_WIDTH'(4);
    branch_ex        = 1'b0;
    branch_taken_ex  = 1'b0;
    branch_pc_ex     = '0;
    branch_target_pc = '0;
    mispredict_flush = 1'b0;
    redirect_pc      = '0;
    if (ex_valid && ex_ready && cmp_legal) begin
      branch_ex        = 1'b1;
      branch_taken_ex  = cmp_taken;
      branch_pc_ex     = ex_pc;
      branch_target_pc = target_sum;
      mispredict_flush = (cmp_taken != ex_pred_taken) ||
                         (cmp_taken && ex_pred_taken && (ex_pred_target != target_sum));
      if (mispredict_flush) begin
        redirect_pc = cmp_taken ? target_sum : fallthrough_pc;
      end
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else if (cnt_clr) begin
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else begin
      branch_cnt     <= branch_cnt + CNT_WIDTH'(branch_ex);
      mispredict_cnt <= mispredict_cnt + CNT_WIDTH'(mispredict_flush);
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// Directed scoreboard bench for branch_resolve: expectations are queued when a
// branch enters EX and popped when the resolve cycle is sampled.
module tb_branch_resolve;
  import branch_resolve_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 4;

  logic          cpu_clk = 1'b0;
  logic          cpu_rstn;
  logic          if_valid;
  logic          predict_taken;
  logic [AW-1:0] predict_target_pc;
  logic          dec_ready;
  logic          ex_ready;
  logic          branch_dec;
  logic [2:0]    funct3_dec;
  logic [AW-1:0] pc_dec;
  logic [AW-1:0] imm_dec;
  logic [DW-1:0] src_data1_ex;
  logic [DW-1:0] src_data2_ex;
  logic          flush_ext;
  logic          cnt_clr;
  logic          branch_ex;
  logic          branch_taken_ex;
  logic [AW-1:0] branch_pc_ex;
  logic [AW-1:0] branch_target_pc;
  logic          mispredict_flush;
  logic [AW-1:0] redirect_pc;
  logic [CW-1:0] branch_cnt;
  logic [CW-1:0] mispredict_cnt;

  always #5 cpu_clk = ~cpu_clk;

  branch_resolve #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .CNT_WIDTH (CW)
  ) dut (
    .cpu_clk          (cpu_clk),
    .cpu_rstn         (cpu_rstn),
    .if_valid         (if_valid),
    .predict_taken    (predict_taken),
    .predict_target_pc(predict_target_pc),
    .dec_ready        (dec_ready),
    .ex_ready         (ex_ready),
    .branch_dec       (branch_dec),
    .funct3_dec       (funct3_dec),
    .pc_dec           (pc_dec),
    .imm_dec          (imm_dec),
    .src_data1_ex     (src_data1_ex),
    .src_data2_ex     (src_data2_ex),
    .flush_ext        (flush_ext),
    .cnt_clr          (cnt_clr),
    .branch_ex        (branch_ex),
    .branch_taken_ex  (branch_taken_ex),
    .branch_pc_ex     (branch_pc_ex),
    .branch_target_pc (branch_target_pc),
    .mispredict_flush (mispredict_flush),
    .redirect_pc      (redirect_pc),
    .branch_cnt       (branch_cnt),
    .mispredict_cnt   (mispredict_cnt)
  );

  typedef struct packed {
    logic          taken;
    logic [AW-1:0] pc;
    logic [AW-1:0] target;
    logic          flush;
    logic [AW-1:0] redirect;
  } exp_t;

  exp_t          sb[$];
  int            tests_run    = 0;
  int            tests_failed = 0;
  logic [CW-1:0] exp_bcnt     = '0;
  logic [CW-1:0] exp_mcnt     = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference compare written from the ISA definition, not the RTL structure.
  function automatic logic model_taken(input logic [2:0] f3, input logic [DW-1:0] a,
                                       input logic [DW-1:0] b);
    logic slt;
    slt = (a[DW-1] != b[DW-1]) ? a[DW-1] : (a < b);
    case (f3)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return slt;
      3'b101:  return !slt;
      3'b110:  return a < b;
      3'b111:  return !(a < b);
      default: return 1'b0;
    endcase
  endfunction

  function automatic exp_t make_exp(input logic [2:0] f3, input logic [AW-1:0] pc,
                                    input logic [AW-1:0] imm, input logic pt,
                                    input logic [AW-1:0] ptgt, input logic [DW-1:0] a,
                                    input logic [DW-1:0] b);
    exp_t e;
    e.taken    = model_taken(f3, a, b);
    e.pc       = pc;
    e.target   = pc + imm;
    e.flush    = (e.taken != pt) || (e.taken && pt && (ptgt != e.target));
    e.redirect = e.flush ? (e.taken ? e.target : pc + 32'd4) : '0;
    return e;
  endfunction

  task automatic idle_inputs();
    if_valid          = 1'b0;
    predict_taken     = 1'b0;
    predict_target_pc = '0;
    dec_ready         = 1'b0;
    ex_ready          = 1'b0;
    branch_dec        = 1'b0;
    funct3_dec        = 3'b000;
    pc_dec            = '0;
    imm_dec           = '0;
    src_data1_ex      = $urandom();
    src_data2_ex      = $urandom();
    flush_ext         = 1'b0;
    cnt_clr           = 1'b0;
  endtask

  task automatic checkOutput(input logic exp_strobe, input string tag);
    exp_t e;
    logic mis;
    mis = 1'b0;
    check({tag, ":branch_cnt"}, 32'(branch_cnt), 32'(exp_bcnt));
    check({tag, ":mispredict_cnt"}, 32'(mispredict_cnt), 32'(exp_mcnt));
    check({tag, ":branch_ex"}, 32'(branch_ex), 32'(exp_strobe));
    if (exp_strobe) begin
      check({tag, ":sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        mis = e.flush;
        check({tag, ":taken"}, 32'(branch_taken_ex), 32'(e.taken));
        check({tag, ":pc"}, branch_pc_ex, e.pc);
        check({tag, ":target"}, branch_target_pc, e.target);
        check({tag, ":flush"}, 32'(mispredict_flush), 32'(e.flush));
        check({tag, ":redirect"}, redirect_pc, e.redirect);
      end
    end else begin
      check({tag, ":flush_idle"}, 32'(mispredict_flush), 32'd0);
      check({tag, ":redirect_idle"}, redirect_pc, 32'd0);
      check({tag, ":pc_idle"}, branch_pc_ex, 32'd0);
    end
    if (cnt_clr) begin
      exp_bcnt = '0;
      exp_mcnt = '0;
    end else if (cpu_rstn) begin
      exp_bcnt = exp_bcnt + CW'(exp_strobe);
      exp_mcnt = exp_mcnt + CW'(mis);
    end
  endtask

  // Walks one branch through IF, DEC, optional EX stalls, then the EX resolve cycle.
  task automatic applyStimulus(input string tag, input logic [2:0] f3, input logic [AW-1:0] pc,
                               input logic [AW-1:0] imm, input logic pt,
                               input logic [AW-1:0] ptgt, input logic [DW-1:0] a,
                               input logic [DW-1:0] b, input int stall,
                               input logic flush_dec, input logic flush_at_ex,
                               input logic clr_at_ex);
    logic strobe;
    @(negedge cpu_clk);
    idle_inputs();
    if_valid          = 1'b1;
    predict_taken     = pt;
    predict_target_pc = ptgt;
    dec_ready         = 1'b1;
    ex_ready          = 1'b1;
    #1 checkOutput(1'b0, {tag, "/if"});
    @(negedge cpu_clk);
    idle_inputs();
    dec_ready  = 1'b1;
    ex_ready   = 1'b1;
    branch_dec = 1'b1;
    funct3_dec = f3;
    pc_dec     = pc;
    imm_dec    = imm;
    flush_ext  = flush_dec;
    #1 checkOutput(1'b0, {tag, "/dec"});
    for (int i = 0; i < stall; i++) begin
      @(negedge cpu_clk);
      idle_inputs();
      #1 checkOutput(1'b0, {tag, "/stall"});
    end
    @(negedge cpu_clk);
    idle_inputs();
    ex_ready     = 1'b1;
    src_data1_ex = a;
    src_data2_ex = b;
    flush_ext    = flush_at_ex;
    cnt_clr      = clr_at_ex;
    strobe = (f3 != 3'b010) && (f3 != 3'b011) && !flush_dec;
    if (strobe) sb.push_back(make_exp(f3, pc, imm, pt, ptgt, a, b));
    #1 checkOutput(strobe, {tag, "/ex"});
  endtask

  initial begin
    idle_inputs();
    cpu_rstn   = 1'b0;
    if_valid   = 1'b1;
    dec_ready  = 1'b1;
    ex_ready   = 1'b1;
    branch_dec = 1'b1;
    #12 checkOutput(1'b0, "reset");
    @(negedge cpu_clk);
    idle_inputs();
    cpu_rstn = 1'b1;
    #1 checkOutput(1'b0, "post_reset");

    applyStimulus("beq_mispred", 3'b000, 32'h100, 32'h20, 1'b0, 32'h0, 32'd5, 32'd5, 0, 0, 0, 0);
    applyStimulus("blt_signed", 3'b100, 32'h200, 32'h40, 1'b1, 32'h240, 32'hFFFF_FFFF, 32'd1, 0, 0, 0, 0);
    applyStimulus("bltu_pred_t", 3'b110, 32'h300, 32'h40, 1'b1, 32'h340, 32'hFFFF_FFFF, 32'd1, 0, 0, 0, 0);
    applyStimulus("tgt_mismatch", 3'b000, 32'h100, 32'h20, 1'b1, 32'h200, 32'd9, 32'd9, 0, 0, 0, 0);
    applyStimulus("tgt_match", 3'b000, 32'h100, 32'h20, 1'b1, 32'h120, 32'd9, 32'd9, 0, 0, 0, 0);
    applyStimulus("bne", 3'b001, 32'h400, 32'hFFFF_FFF0, 1'b0, 32'h0, 32'd3, 32'd4, 0, 0, 0, 0);
    applyStimulus("bge_neg", 3'b101, 32'h500, 32'h8, 1'b1, 32'h508, 32'h8000_0000, 32'd0, 0, 0, 0, 0);
    applyStimulus("bgeu", 3'b111, 32'hFFFF_FFF0, 32'h20, 1'b1, 32'h10, 32'h8000_0000, 32'd0, 0, 0, 0, 0);
    applyStimulus("stall3", 3'b101, 32'h600, 32'h10, 1'b0, 32'h0, 32'd7, 32'd7, 3, 0, 0, 0);
    applyStimulus("ext_flush_dec", 3'b000, 32'h700, 32'h10, 1'b0, 32'h0, 32'd1, 32'd1, 0, 1, 0, 0);
    applyStimulus("illegal_010", 3'b010, 32'h800, 32'h10, 1'b0, 32'h0, 32'd1, 32'd1, 0, 0, 0, 0);
    applyStimulus("illegal_011", 3'b011, 32'h800, 32'h10, 1'b1, 32'h810, 32'd1, 32'd2, 0, 0, 0, 0);
    applyStimulus("ext_flush_ex", 3'b001, 32'h900, 32'h30, 1'b0, 32'h0, 32'd1, 32'd2, 0, 0, 1, 0);
    applyStimulus("clr_mispred", 3'b000, 32'hA00, 32'h4, 1'b0, 32'h0, 32'd6, 32'd6, 0, 0, 0, 1);

    // A mispredict in EX must keep the younger branch in DEC out of EX.
    @(negedge cpu_clk);
    idle_inputs();
    if_valid  = 1'b1;
    dec_ready = 1'b1;
    ex_ready  = 1'b1;
    #1 checkOutput(1'b0, "kill/if_a");
    @(negedge cpu_clk);
    idle_inputs();
    if_valid   = 1'b1;
    dec_ready  = 1'b1;
    ex_ready   = 1'b1;
    branch_dec = 1'b1;
    pc_dec     = 32'h300;
    imm_dec    = 32'h8;
    #1 checkOutput(1'b0, "kill/dec_a");
    @(negedge cpu_clk);
    idle_inputs();
    dec_ready    = 1'b1;
    ex_ready     = 1'b1;
    branch_dec   = 1'b1;
    pc_dec       = 32'h304;
    imm_dec      = 32'h8;
    src_data1_ex = 32'd7;
    src_data2_ex = 32'd7;
    sb.push_back(make_exp(3'b000, 32'h300, 32'h8, 1'b0, 32'h0, 32'd7, 32'd7));
    #1 checkOutput(1'b1, "kill/ex_a");
    @(negedge cpu_clk);
    idle_inputs();
    ex_ready     = 1'b1;
    src_data1_ex = 32'd7;
    src_data2_ex = 32'd7;
    #1 checkOutput(1'b0, "kill/ex_b");

    // Reset asserted while a valid branch is stalled in EX.
    applyStimulus("pre_rst", 3'b000, 32'hB00, 32'h10, 1'b0, 32'h0, 32'd1, 32'd1, 0, 0, 0, 0);
    @(negedge cpu_clk);
    idle_inputs();
    if_valid  = 1'b1;
    dec_ready = 1'b1;
    ex_ready  = 1'b1;
    #1 checkOutput(1'b0, "rst/if");
    @(negedge cpu_clk);
    idle_inputs();
    dec_ready  = 1'b1;
    ex_ready   = 1'b1;
    branch_dec = 1'b1;
    pc_dec     = 32'hC00;
    #1 checkOutput(1'b0, "rst/dec");
    @(negedge cpu_clk);
    idle_inputs();
    #1 checkOutput(1'b0, "rst/stall");
    #2 cpu_rstn = 1'b0;
    exp_bcnt = '0;
    exp_mcnt = '0;
    #1 checkOutput(1'b0, "rst/async");
    @(negedge cpu_clk);
    idle_inputs();
    cpu_rstn     = 1'b1;
    ex_ready     = 1'b1;
    src_data1_ex = 32'd0;
    src_data2_ex = 32'd0;
    #1 checkOutput(1'b0, "rst/release");

    // Drive the branch counter to all-ones, then one more to wrap it.
    for (int i = 0; i < 20 && exp_bcnt != '1; i++) begin
      applyStimulus("fill", 3'b000, 32'hD00, 32'h10, 1'b0, 32'h0, 32'd1, 32'd2, 0, 0, 0, 0);
    end
    check("fill_reached_max", 32'(exp_bcnt), 32'hF);
    applyStimulus("wrap", 3'b000, 32'hE00, 32'h10, 1'b1, 32'hE10, 32'd4, 32'd4, 0, 0, 0, 0);
    @(negedge cpu_clk);
    idle_inputs();
    #1 checkOutput(1'b0, "wrap/after");
    check("wrap_zero", 32'(branch_cnt), 32'd0);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
